// File: rtl/mem_wait_stage.sv
// Mem/WB stage with a private data memory that is accessed with WAIT_CYC wait states.
// Optional last-store forwarding is enabled by defining MEM_FWD_EN.
module mem_wait_stage #(
  parameter int DSIZE    = 16,
  parameter int ASIZE    = 10,
  parameter int RSIZE    = 3,
  parameter int WAIT_CYC = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             ex_valid,
  input  logic [DSIZE-1:0] ALUResult_mem,
  input  logic [DSIZE-1:0] readData1,
  input  logic             memEnab,
  input  logic             memWriteEnab,
  input  logic             sel_mem2reg,
  input  logic [RSIZE-1:0] ex_rd,
  input  logic             ex_regWrite,
  output logic             stall,
  output logic [DSIZE-1:0] WB_writeData,
  output logic [RSIZE-1:0] WB_rd,
  output logic             WB_regWrite
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam bit         ZERO_WAIT = (WAIT_CYC == 0);
  localparam logic [3:0] CNT_INIT  = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  state_t           r_state, w_state_next;
  logic [3:0]       r_cnt, w_cnt_next;
  logic             w_commit, w_stall;
  logic             w_req, w_store, w_hit;
  logic [ASIZE-1:0] w_addr;
  logic [DSIZE-1:0] w_rd_data;
  logic [DSIZE-1:0] r_wb_data;
  logic [RSIZE-1:0] r_wb_rd;
  logic             r_wb_rw;

  logic [DSIZE-1:0] r_mem [0:(1<<ASIZE)-1];

  // Upper address bits are deliberately ignored so addresses wrap.
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^ALUResult_mem[DSIZE-1:ASIZE];

  assign w_addr  = ALUResult_mem[ASIZE-1:0];
  assign w_req   = ex_valid & memEnab;
  assign w_store = w_req & memWriteEnab;

`ifdef MEM_FWD_EN
  logic [ASIZE-1:0] r_fwd_addr;
  logic [DSIZE-1:0] r_fwd_data;
  logic             r_fwd_valid;

  assign w_hit     = (r_state == IDLE) & w_req & ~memWriteEnab & r_fwd_valid
                     & (r_fwd_addr == w_addr);
  assign w_rd_data = w_hit ? r_fwd_data : r_mem[w_addr];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_fwd_addr  <= '0;
      r_fwd_data  <= '0;
      r_fwd_valid <= 1'b0;
    end else if (w_commit && w_store) begin
      r_fwd_addr  <= w_addr;
      r_fwd_data  <= readData1;
      r_fwd_valid <= 1'b1;
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_rd_data = r_mem[w_addr];
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_commit     = 1'b0;
    w_stall      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_req || ZERO_WAIT || w_hit) begin
          w_commit = 1'b1;
        end else begin
          w_stall      = 1'b1;
          w_state_next = BUSY;
          w_cnt_next   = CNT_INIT;
        end
      end
      BUSY: begin
        if (r_cnt != 4'd0) begin
          w_stall    = 1'b1;
          w_cnt_next = r_cnt - 4'd1;
        end else begin
          w_commit     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Any non-committing edge, and any bubble, leaves a zero write strobe.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_wb_data <= '0;
      r_wb_rd   <= '0;
      r_wb_rw   <= 1'b0;
    end else if (w_commit && ex_valid) begin
      r_wb_data <= sel_mem2reg ? w_rd_data : ALUResult_mem;
      r_wb_rd   <= ex_rd;
      r_wb_rw   <= ex_regWrite;
    end else begin
      r_wb_rw   <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_commit && w_store) begin
      r_mem[w_addr] <= readData1;
    end
  end

  assign stall        = w_stall & Rst;
  assign WB_writeData = r_wb_data;
  assign WB_rd        = r_wb_rd;
  assign WB_regWrite  = r_wb_rw;

endmodule

// File: tb/tb_mem_wait_stage.sv
// Directed plus randomized bench for mem_wait_stage against a transaction-level model.
// Expectations follow MEM_FWD_EN when it is defined for the build.
module tb_mem_wait_stage;
  localparam int DSIZE = 16;
  localparam int ASIZE = 10;
  localparam int RSIZE = 3;
  localparam int WAITC = 2;
  localparam int DEPTH = 1 << ASIZE;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             ex_valid, memEnab, memWriteEnab, sel_mem2reg, ex_regWrite;
  logic [DSIZE-1:0] ALUResult_mem, readData1;
  logic [RSIZE-1:0] ex_rd;
  logic             stall, WB_regWrite;
  logic [DSIZE-1:0] WB_writeData;
  logic [RSIZE-1:0] WB_rd;

  int total = 0;
  int bad   = 0;

  // Reference model: memory contents, which words are defined, last store, WB state.
  logic [DSIZE-1:0] m_mem [DEPTH];
  bit               m_wr  [DEPTH];
  int               m_last_addr;
  bit               m_last_valid;
  logic [DSIZE-1:0] m_wb_data;
  logic [RSIZE-1:0] m_wb_rd;
  logic             m_wb_rw;
  bit               m_wb_known;

  mem_wait_stage #(.DSIZE(DSIZE), .ASIZE(ASIZE), .RSIZE(RSIZE), .WAIT_CYC(WAITC)) dut (
    .Clk(Clk), .Rst(Rst), .ex_valid(ex_valid), .ALUResult_mem(ALUResult_mem),
    .readData1(readData1), .memEnab(memEnab), .memWriteEnab(memWriteEnab),
    .sel_mem2reg(sel_mem2reg), .ex_rd(ex_rd), .ex_regWrite(ex_regWrite),
    .stall(stall), .WB_writeData(WB_writeData), .WB_rd(WB_rd), .WB_regWrite(WB_regWrite)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wb_data    = '0;
    m_wb_rd      = '0;
    m_wb_rw      = 1'b0;
    m_wb_known   = 1'b1;
    m_last_valid = 1'b0;
  endtask

  // Present one instruction, follow it through any stall, check the commit.
  task automatic run_instr(input bit v, input bit me, input bit we, input bit sel, input bit rw,
                           input logic [15:0] alu, input logic [15:0] sd,
                           input logic [2:0] rd, input string tag);
    int  addr, exp_stall, n;
    bit  req, hit, done;
    ex_valid = v; memEnab = me; memWriteEnab = we; sel_mem2reg = sel;
    ex_regWrite = rw; ALUResult_mem = alu; readData1 = sd; ex_rd = rd;
    addr = int'(alu) % DEPTH;
    req  = v && me;
    hit  = 1'b0;
`ifdef MEM_FWD_EN
    hit  = req && !we && m_last_valid && (m_last_addr == addr);
`endif
    exp_stall = (req && WAITC > 0 && !hit) ? WAITC : 0;
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (!stall) begin
        done = 1'b1;
        break;
      end
      n++;
      @(posedge Clk); #1;
      chk({tag, ":bubble_rw"}, 32'(WB_regWrite), 32'd0);
    end
    if (!done) begin
      total++;
      bad++;
      $error("FAIL %s:timeout got stall stuck want release", tag);
    end
    @(posedge Clk); #1;
    if (v) begin
      if (sel) begin
        m_wb_known = m_wr[addr];
        m_wb_data  = m_mem[addr];
      end else begin
        m_wb_known = 1'b1;
        m_wb_data  = alu;
      end
      m_wb_rd = rd;
      m_wb_rw = rw;
    end else begin
      m_wb_rw = 1'b0;
    end
    if (req && we) begin
      m_mem[addr]  = sd;
      m_wr[addr]   = 1'b1;
      m_last_addr  = addr;
      m_last_valid = 1'b1;
    end
    chk({tag, ":stall_cycles"}, 32'(n), 32'(exp_stall));
    chk({tag, ":WB_regWrite"}, 32'(WB_regWrite), 32'(m_wb_rw));
    chk({tag, ":WB_rd"}, 32'(WB_rd), 32'(m_wb_rd));
    if (m_wb_known) chk({tag, ":WB_writeData"}, 32'(WB_writeData), 32'(m_wb_data));
    $display("txn %-10s v=%0d me=%0d we=%0d sel=%0d alu=%h sd=%h rd=%0d stalls=%0d wb=%h/%0d/%0d",
             tag, v, me, we, sel, alu, sd, rd, n, WB_writeData, WB_rd, WB_regWrite);
  endtask

  initial begin
    logic [15:0] pool [8];
    pool[0] = 16'h0010; pool[1] = 16'h03FF; pool[2] = 16'h0000; pool[3] = 16'h0123;
    pool[4] = 16'h0200; pool[5] = 16'h0055; pool[6] = 16'h02AA; pool[7] = 16'h0011;
    for (int i = 0; i < DEPTH; i++) m_wr[i] = 1'b0;
    m_last_addr = 0;
    model_reset();

    Rst = 1'b0;
    ex_valid = 0; memEnab = 0; memWriteEnab = 0; sel_mem2reg = 0; ex_regWrite = 0;
    ALUResult_mem = '0; readData1 = '0; ex_rd = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst:WB_writeData", 32'(WB_writeData), 32'd0);
    chk("rst:WB_rd", 32'(WB_rd), 32'd0);
    chk("rst:WB_regWrite", 32'(WB_regWrite), 32'd0);
    chk("rst:stall", 32'(stall), 32'd0);
    @(negedge Clk) Rst = 1'b1;
    @(posedge Clk); #1;

    // Reset asserted in the middle of a store's wait states.
    ex_valid = 1; memEnab = 1; memWriteEnab = 1; sel_mem2reg = 0; ex_regWrite = 0;
    ALUResult_mem = 16'h0005; readData1 = 16'hBEEF; ex_rd = 3'd1;
    @(negedge Clk);
    chk("midrst:stall_idle", 32'(stall), 32'd1);
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("midrst:stall_busy", 32'(stall), 32'd1);
    Rst = 1'b0;
    #1;
    chk("midrst:stall", 32'(stall), 32'd0);
    chk("midrst:WB_writeData", 32'(WB_writeData), 32'd0);
    chk("midrst:WB_rd", 32'(WB_rd), 32'd0);
    chk("midrst:WB_regWrite", 32'(WB_regWrite), 32'd0);
    @(posedge Clk); #1;
    ex_valid = 0;
    @(negedge Clk) Rst = 1'b1;
    model_reset();
    @(posedge Clk); #1;
    $display("txn reset     mid-busy store aborted");

    run_instr(1, 0, 0, 0, 1, 16'h1234, 16'h0000, 3'd3, "alu");
    run_instr(1, 1, 1, 0, 0, 16'h0010, 16'hA5A5, 3'd2, "store");
    run_instr(1, 1, 0, 1, 1, 16'h0010, 16'h0000, 3'd5, "load");
    run_instr(1, 1, 1, 0, 0, 16'h0410, 16'h0F0F, 3'd0, "st_wrap");
    run_instr(1, 1, 0, 1, 1, 16'h0010, 16'h0000, 3'd6, "ld_wrap");
    for (int i = 0; i < 3; i++)
      run_instr(0, 1, 1, 1, 1, 16'h0010, 16'hDEAD, 3'd7, "bubble");
    chk("hold:WB_writeData", 32'(WB_writeData), 32'h0F0F);
    run_instr(1, 0, 1, 0, 0, 16'h0010, 16'h1111, 3'd4, "we_no_en");
    run_instr(1, 1, 0, 1, 1, 16'h0010, 16'h0000, 3'd1, "ld_after");
    run_instr(1, 1, 0, 1, 1, 16'h0005, 16'h0000, 3'd2, "ld_rst5");
    total++;
    assert (WB_writeData !== 16'hBEEF) else begin
      bad++;
      $error("FAIL ld_rst5:aborted_store got %h want not BEEF", WB_writeData);
    end

    for (int t = 0; t < 300; t++) begin
      int          op;
      logic [15:0] a, d;
      logic [2:0]  r;
      op = int'($urandom_range(0, 3));
      a  = pool[$urandom_range(0, 7)] | (16'($urandom_range(0, 63)) << 10);
      d  = 16'($urandom);
      r  = 3'($urandom);
      if (op == 2 && !m_wr[int'(a) % DEPTH]) op = 0;
      case (op)
        0: run_instr(1, 0, 1'($urandom), 0, 1'($urandom), 16'($urandom), d, r, "r_alu");
        1: run_instr(1, 1, 1, 0, 1'($urandom), a, d, r, "r_store");
        2: run_instr(1, 1, 0, 1, 1'($urandom), a, d, r, "r_load");
        default: run_instr(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), a, d, r, "r_bubble");
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
